// File: rtl/facto_slave.sv
// Bus-mapped register front end for a factorial controller: start/clear control, operand, captured result, interrupt.
// Register writes land on the clock edge; reads are combinational; the result is captured on the first op_done seen while running.
module facto_slave (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          s_sel,
   input  logic          s_wr,
   input  logic [7:0]    s_addr,
   input  logic [63:0]   s_din,
   output logic [63:0]   s_dout,
   output logic          op_start,
   output logic          op_clear,
   output logic [63:0]   oper,
   input  logic          op_done,
   input  logic [127:0]  result,
   output logic          interrupt
);

   localparam logic [7:0] A_OPSTART  = 8'h00;
   localparam logic [7:0] A_OPCLEAR  = 8'h08;
   localparam logic [7:0] A_OPDONE   = 8'h10;
   localparam logic [7:0] A_INTREN   = 8'h18;
   localparam logic [7:0] A_OPERAND  = 8'h20;
   localparam logic [7:0] A_RESULT_H = 8'h28;
   localparam logic [7:0] A_RESULT_L = 8'h30;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         r_state;
   logic           r_opstart;
   logic           r_opdone;
   logic           r_intren;
   logic           r_op_clear;
   logic [63:0]    r_operand;
   logic [127:0]   r_result;

   logic           w_wr;
   logic           w_clr;
   logic [63:0]    w_rdata;

   assign w_wr  = s_sel & s_wr;
   assign w_clr = w_wr && (s_addr == A_OPCLEAR) && s_din[0];

   // Clear is checked ahead of the state machine so it wins over a coincident op_done.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_opstart  <= 1'b0;
         r_opdone   <= 1'b0;
         r_intren   <= 1'b0;
         r_op_clear <= 1'b0;
         r_operand  <= '0;
         r_result   <= '0;
      end else begin
         r_op_clear <= w_clr;
         if (w_wr && (s_addr == A_INTREN))
            r_intren <= s_din[0];
         if (w_clr) begin
            r_state   <= IDLE;
            r_opstart <= 1'b0;
            r_opdone  <= 1'b0;
            r_result  <= '0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (w_wr && (s_addr == A_OPERAND))
                     r_operand <= s_din;
                  if (w_wr && (s_addr == A_OPSTART) && s_din[0]) begin
                     r_opstart <= 1'b1;
                     r_state   <= RUN;
                  end
               end
               RUN: begin
                  if (op_done) begin
                     r_result <= result;
                     r_opdone <= 1'b1;
                     r_state  <= DONE;
                  end
               end
               DONE: begin
                  r_state <= DONE;
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   always_comb begin
      w_rdata = '0;
      if (s_sel && !s_wr) begin
         case (s_addr)
            A_OPSTART:  w_rdata = {63'd0, r_opstart};
            A_OPDONE:   w_rdata = {63'd0, r_opdone};
            A_INTREN:   w_rdata = {63'd0, r_intren};
            A_OPERAND:  w_rdata = r_operand;
            A_RESULT_H: w_rdata = r_result[127:64];
            A_RESULT_L: w_rdata = r_result[63:0];
            default:    w_rdata = '0;
         endcase
      end
   end

   assign s_dout    = w_rdata;
   assign op_start  = r_opstart;
   assign op_clear  = r_op_clear;
   assign oper      = r_operand;
   assign interrupt = r_opdone & r_intren;

endmodule

// File: tb/tb_facto_slave.sv
// Self-checking bench for facto_slave: register-map vector table, directed corner sequences,
// and randomized factorial runs against a behavioural controller and expectation model.
module tb_facto_slave;

   localparam logic [7:0] OPSTART  = 8'h00;
   localparam logic [7:0] OPCLEAR  = 8'h08;
   localparam logic [7:0] OPDONE   = 8'h10;
   localparam logic [7:0] INTREN   = 8'h18;
   localparam logic [7:0] OPERAND  = 8'h20;
   localparam logic [7:0] RESULT_H = 8'h28;
   localparam logic [7:0] RESULT_L = 8'h30;
   localparam logic [7:0] UNMAPPED = 8'h38;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          s_sel = 1'b0;
   logic          s_wr = 1'b0;
   logic [7:0]    s_addr = 8'h00;
   logic [63:0]   s_din = 64'd0;
   logic [63:0]   s_dout;
   logic          op_start;
   logic          op_clear;
   logic [63:0]   oper;
   logic          op_done = 1'b0;
   logic [127:0]  result = 128'd0;
   logic          interrupt;

   int n_cmp = 0;
   int n_err = 0;

   facto_slave dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .s_sel     (s_sel),
      .s_wr      (s_wr),
      .s_addr    (s_addr),
      .s_din     (s_din),
      .s_dout    (s_dout),
      .op_start  (op_start),
      .op_clear  (op_clear),
      .oper      (oper),
      .op_done   (op_done),
      .result    (result),
      .interrupt (interrupt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          wr;
      logic [7:0]    addr;
      logic [63:0]   wdat;
      logic [63:0]   exp_rd;
   } vec_t;

   vec_t vecs[15];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] fact(input int n);
      logic [127:0] f;
      f = 128'd1;
      for (int i = 2; i <= n; i++) f = f * 128'(i);
      return f;
   endfunction

   task automatic bus_write(input logic [7:0] a, input logic [63:0] d);
      @(negedge clk);
      s_sel = 1'b1; s_wr = 1'b1; s_addr = a; s_din = d;
      @(posedge clk);
      #1;
      s_sel = 1'b0; s_wr = 1'b0; s_din = 64'd0;
   endtask

   task automatic bus_read(input logic [7:0] a, output logic [63:0] d);
      @(negedge clk);
      s_sel = 1'b1; s_wr = 1'b0; s_addr = a;
      #1;
      d = s_dout;
      s_sel = 1'b0;
   endtask

   task automatic read_check(input string name, input logic [7:0] a, input logic [63:0] exp);
      logic [63:0] d;
      bus_read(a, d);
      check(name, {64'd0, d}, {64'd0, exp});
   endtask

   // OPCLEAR write; op_clear must be high only in the cycle after the write edge.
   task automatic clear_op(input string name);
      bus_write(OPCLEAR, 64'd1);
      check({name, "_pulse"}, {127'd0, op_clear}, 128'd1);
      @(posedge clk);
      #1;
      check({name, "_pulse_end"}, {127'd0, op_clear}, 128'd0);
   endtask

   // Behavioural controller: raises op_done for one edge after a delay.
   task automatic ctrl_done(input logic [127:0] res, input int dly);
      repeat (dly) @(negedge clk);
      @(negedge clk);
      op_done = 1'b1; result = res;
      @(negedge clk);
      op_done = 1'b0;
   endtask

   initial begin
      int          n;
      logic        ie;
      logic        junk_wr;
      logic [63:0] junk;
      logic [127:0] exp_res;

      vecs[0]  = '{1'b1, INTREN,   64'd1,                   64'd0};
      vecs[1]  = '{1'b0, INTREN,   64'd0,                   64'd1};
      vecs[2]  = '{1'b1, OPERAND,  64'h0123_4567_89AB_CDEF, 64'd0};
      vecs[3]  = '{1'b0, OPERAND,  64'd0,                   64'h0123_4567_89AB_CDEF};
      vecs[4]  = '{1'b0, OPCLEAR,  64'd0,                   64'd0};
      vecs[5]  = '{1'b1, UNMAPPED, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
      vecs[6]  = '{1'b0, UNMAPPED, 64'd0,                   64'd0};
      vecs[7]  = '{1'b0, OPERAND,  64'd0,                   64'h0123_4567_89AB_CDEF};
      vecs[8]  = '{1'b0, INTREN,   64'd0,                   64'd1};
      vecs[9]  = '{1'b1, OPSTART,  64'hFFFF_FFFF_FFFF_FFFE, 64'd0};
      vecs[10] = '{1'b0, OPSTART,  64'd0,                   64'd0};
      vecs[11] = '{1'b0, OPDONE,   64'd0,                   64'd0};
      vecs[12] = '{1'b0, RESULT_H, 64'd0,                   64'd0};
      vecs[13] = '{1'b1, INTREN,   64'd0,                   64'd0};
      vecs[14] = '{1'b0, INTREN,   64'd0,                   64'd0};

      // Reset state
      #12;
      check("rst_op_start",  {127'd0, op_start},  128'd0);
      check("rst_op_clear",  {127'd0, op_clear},  128'd0);
      check("rst_oper",      {64'd0, oper},       128'd0);
      check("rst_interrupt", {127'd0, interrupt}, 128'd0);
      reset_n = 1'b1;
      read_check("rst_result_l", RESULT_L, 64'd0);

      // Register map table
      for (int i = 0; i < 15; i++) begin
         if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdat);
         else read_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_rd);
      end
      check("vec_oper", {64'd0, oper}, {64'd0, 64'h0123_4567_89AB_CDEF});
      check("vec_op_start", {127'd0, op_start}, 128'd0);

      // op_done while idle is ignored
      ctrl_done(128'd99, 0);
      read_check("idle_done_opdone", OPDONE, 64'd0);
      read_check("idle_done_result", RESULT_L, 64'd0);

      // 5! with interrupt enabled; later op_done in DONE ignored
      bus_write(OPERAND, 64'd5);
      bus_write(INTREN, 64'd1);
      bus_write(OPSTART, 64'd1);
      check("f5_op_start_run", {127'd0, op_start}, 128'd1);
      check("f5_oper", {64'd0, oper}, 128'd5);
      ctrl_done(128'd120, 3);
      read_check("f5_result_l", RESULT_L, 64'd120);
      read_check("f5_result_h", RESULT_H, 64'd0);
      read_check("f5_opdone", OPDONE, 64'd1);
      read_check("f5_opdone_reread", OPDONE, 64'd1);
      check("f5_interrupt", {127'd0, interrupt}, 128'd1);
      check("f5_op_start_done", {127'd0, op_start}, 128'd1);
      ctrl_done(128'd777, 1);
      read_check("f5_done_hold", RESULT_L, 64'd120);
      clear_op("f5_clr");
      check("f5_clr_op_start", {127'd0, op_start}, 128'd0);
      check("f5_clr_interrupt", {127'd0, interrupt}, 128'd0);
      read_check("f5_clr_result", RESULT_L, 64'd0);
      read_check("f5_clr_intren", INTREN, 64'd1);

      // 20! with interrupt disabled
      bus_write(INTREN, 64'd0);
      bus_write(OPERAND, 64'd20);
      bus_write(OPSTART, 64'd1);
      ctrl_done(fact(20), 2);
      read_check("f20_result_l", RESULT_L, 64'd2432902008176640000);
      read_check("f20_result_h", RESULT_H, 64'd0);
      read_check("f20_opdone", OPDONE, 64'd1);
      check("f20_interrupt", {127'd0, interrupt}, 128'd0);
      clear_op("f20_clr");

      // Writes during RUN are ignored
      bus_write(OPERAND, 64'd5);
      bus_write(OPSTART, 64'd1);
      bus_write(OPERAND, 64'd7);
      bus_write(OPSTART, 64'd1);
      check("run_oper_locked", {64'd0, oper}, 128'd5);
      check("run_op_start", {127'd0, op_start}, 128'd1);
      read_check("run_opdone", OPDONE, 64'd0);
      clear_op("run_clr");
      check("run_clr_op_start", {127'd0, op_start}, 128'd0);
      read_check("run_clr_opdone", OPDONE, 64'd0);
      check("run_clr_oper", {64'd0, oper}, 128'd5);

      // Clear coincident with op_done: clear wins
      bus_write(INTREN, 64'd1);
      bus_write(OPSTART, 64'd1);
      @(negedge clk);
      s_sel = 1'b1; s_wr = 1'b1; s_addr = OPCLEAR; s_din = 64'd1;
      op_done = 1'b1; result = 128'd120;
      @(posedge clk);
      #1;
      s_sel = 1'b0; s_wr = 1'b0; s_din = 64'd0;
      check("coin_op_clear", {127'd0, op_clear}, 128'd1);
      @(negedge clk);
      op_done = 1'b0;
      check("coin_interrupt", {127'd0, interrupt}, 128'd0);
      check("coin_op_start", {127'd0, op_start}, 128'd0);
      read_check("coin_result_l", RESULT_L, 64'd0);
      read_check("coin_opdone", OPDONE, 64'd0);
      bus_write(OPSTART, 64'd1);
      check("coin_idle_restart", {127'd0, op_start}, 128'd1);

      // Asynchronous reset mid-RUN
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("arst_op_start",  {127'd0, op_start},  128'd0);
      check("arst_oper",      {64'd0, oper},       128'd0);
      check("arst_op_clear",  {127'd0, op_clear},  128'd0);
      check("arst_interrupt", {127'd0, interrupt}, 128'd0);
      #1 reset_n = 1'b1;
      read_check("arst_opdone", OPDONE, 64'd0);
      bus_write(OPERAND, 64'd3);
      bus_write(OPSTART, 64'd1);
      ctrl_done(fact(int'(oper)), 1);
      read_check("arst_f3_result", RESULT_L, 64'd6);
      clear_op("arst_clr");

      // Randomized runs: controller computes n! from oper, model predicts readback
      for (int it = 0; it < 24; it++) begin
         n = $urandom_range(0, 33);
         ie = 1'($urandom_range(0, 1));
         junk_wr = 1'($urandom_range(0, 1));
         junk = {$urandom, $urandom};
         exp_res = fact(n);
         bus_write(INTREN, {63'd0, ie});
         bus_write(OPERAND, 64'(n));
         bus_write(OPSTART, 64'd1);
         if (junk_wr) bus_write(OPERAND, junk);
         check("rnd_oper", {64'd0, oper}, 128'(n));
         ctrl_done(fact(int'(oper)), $urandom_range(0, 4));
         read_check($sformatf("rnd%0d_result_l", it), RESULT_L, exp_res[63:0]);
         read_check($sformatf("rnd%0d_result_h", it), RESULT_H, exp_res[127:64]);
         read_check("rnd_opdone", OPDONE, 64'd1);
         check("rnd_interrupt", {127'd0, interrupt}, {127'd0, ie});
         clear_op("rnd_clr");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/facto_slave.md
FACTO_SLAVE -- requirements
Module: facto_slave

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low, with ports named clk and reset_n.
REQ-002 SHALL provide these ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- s_sel  in  1  bus select
- s_wr  in  1  1=write, 0=read (valid with s_sel)
- s_addr  in  8  byte address; register offsets below
- s_din  in  64  write data
- s_dout  out  64  read data
- op_start  out  1  start level to the factorial controller
- op_clear  out  1  one-cycle clear pulse to the factorial controller
- oper  out  64  signed operand to the factorial controller
- op_done  in  1  completion flag from the factorial controller
- result  in  128  signed factorial result from the factorial controller
- interrupt  out  1  completion interrupt

Function
REQ-003 SHALL implement the register map:
- 0x00 OPSTART, bit0
- 0x08 OPCLEAR, bit0, write-only, reads 0
- 0x10 OPDONE, bit0, read-only
- 0x18 INTREN, bit0
- 0x20 OPERAND, 64 bits
- 0x28 RESULT_H = result[127:64], read-only
- 0x30 RESULT_L = result[63:0], read-only
REQ-004 SHALL treat unmapped addresses as reads of 0 and ignore writes to them.
REQ-005 SHALL drive s_dout combinationally with the addressed register when s_sel=1 and s_wr=0, else 64'd0.
REQ-006 SHALL update registers on the clk edge in which s_sel=1 and s_wr=1.
REQ-007 SHALL implement FSM states IDLE, RUN, DONE.
REQ-008 IDLE -> RUN SHALL occur on a write of OPSTART with s_din[0]=1; OPSTART[0] then SHALL be set.
REQ-009 RUN -> DONE SHALL occur in the first cycle op_done=1; in that edge result SHALL be captured into RESULT_H/RESULT_L and OPDONE[0] SHALL be set.
REQ-010 DONE SHALL hold until an OPCLEAR write; op_done changes in DONE SHALL be ignored.
REQ-011 A write of OPCLEAR with s_din[0]=1 SHALL, from any state:
- pulse op_clear high for exactly one cycle (the cycle after the write edge)
- return the FSM to IDLE
- clear OPSTART, OPDONE, RESULT_H and RESULT_L
- retain OPERAND and INTREN
REQ-012 op_start SHALL equal OPSTART[0], held high through RUN and DONE until cleared.
REQ-013 oper SHALL equal OPERAND at all times.
REQ-014 OPERAND writes SHALL take effect only in IDLE; in RUN/DONE they SHALL be ignored.
REQ-015 OPSTART writes in RUN/DONE SHALL be ignored; an OPSTART write with s_din[0]=0 SHALL be ignored in all states.
REQ-016 interrupt SHALL equal OPDONE[0] & INTREN[0] and SHALL be registered-path only (no combinational path from s_*).
REQ-017 Reading OPDONE SHALL NOT clear it.
REQ-018 If an OPCLEAR write and op_done=1 occur in the same cycle, clear SHALL win: no result capture, state IDLE.
REQ-019 If an OPCLEAR write and an OPSTART write target the same cycle, only one is possible per cycle (single address); no arbitration is needed.
REQ-020 op_done=1 while in IDLE SHALL be ignored.

Reset
REQ-021 reset_n=0 SHALL immediately, independent of clk, set:
- FSM=IDLE
- all registers to 0
- op_start=0, op_clear=0, oper=0, interrupt=0
REQ-022 Reset asserted mid-RUN SHALL abort the operation with no result capture; after release the block SHALL accept a new start.

Verification
REQ-023 Write OPERAND=5, INTREN=1, OPSTART=1; controller returns op_done with result=120 -> RESULT_L=120, RESULT_H=0, OPDONE=1, interrupt=1, op_start still 1.
REQ-024 OPERAND=20, run to completion -> RESULT_L=64'd2432902008176640000, RESULT_H=0; with INTREN=0, interrupt stays 0 while OPDONE=1.
REQ-025 In RUN, write OPERAND=7 and OPSTART=1 -> oper unchanged (5), state RUN; then OPCLEAR=1 -> single op_clear pulse, op_start=0, OPDONE=0, OPERAND still 5.
REQ-026 OPCLEAR write coincident with op_done=1 -> RESULT_L=0, OPDONE=0, state IDLE, interrupt=0.
REQ-027 reset_n pulsed low mid-RUN, between clk edges -> all outputs 0 before the next edge; a subsequent OPERAND=3/OPSTART sequence yields RESULT_L=6.
REQ-028 Read of 0x08 and of unmapped address 0x38 -> s_dout=0; a write to 0x38 changes no register.
